// File: rtl/ternary_regfile_mp_pkg.sv
// Shared types and helpers for the multi-port ternary register file.
// Trits use a 2-bit encoding: 00 = zero, 01 = +1, 10 = -1; 11 is illegal and
// is read as zero wherever a trit is decoded.
package ternary_regfile_mp_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;

    // Widest register address the index decoder accepts.
    localparam int unsigned MaxAddrTrits = 8;

    typedef enum logic [1:0] {
        ClrIdle,
        ClrSweep,
        ClrDone
    } rf_clr_state_e;

    // 3**n, usable in constant expressions.
    function automatic int unsigned pow3(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

    // Unsigned base-3 decode of an address: 0->0, +->1, -->2, illegal->0.
    // Trit 0 is the least significant digit. Callers zero-extend narrower
    // addresses; T_ZERO padding does not change the result.
    function automatic int unsigned trits_to_index(input trit_t [MaxAddrTrits-1:0] t);
        int unsigned idx;
        int unsigned w;
        idx = 0;
        w   = 1;
        for (int k = 0; k < MaxAddrTrits; k++) begin
            case (t[k])
                T_POS:   idx = idx + w;
                T_NEG:   idx = idx + 2 * w;
                default: idx = idx;
            endcase
            w = w * 3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ternary_regfile_mp_if.sv
// Bus bundle between the core and the ternary register file.
//   master : core side (drives addresses, write ports, scoreboard set, clear
//            request, debug index; receives read data and status)
//   slave  : register file side
interface ternary_regfile_mp_if
    import ternary_regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_TRITS = 3,
    parameter int unsigned TRIT_WIDTH = 27,
    parameter int unsigned NUM_RD     = 3
);
    localparam int unsigned NUM_REGS = pow3(ADDR_TRITS);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    trit_t [NUM_RD-1:0][ADDR_TRITS-1:0] rs_addr;
    trit_t [NUM_RD-1:0][TRIT_WIDTH-1:0] rs_data;
    logic  [NUM_RD-1:0]                 rs_busy;

    logic                               wa_en;
    trit_t [ADDR_TRITS-1:0]             wa_addr;
    trit_t [TRIT_WIDTH-1:0]             wa_data;

    logic                               wb_en;
    trit_t [ADDR_TRITS-1:0]             wb_addr;
    trit_t [TRIT_WIDTH-1:0]             wb_data;

    logic                               sb_set_en;
    trit_t [ADDR_TRITS-1:0]             sb_set_addr;

    logic                               clr_req;
    logic                               clr_busy;
    logic                               clr_done;
    logic                               wr_conflict;

    logic  [IDX_W-1:0]                  dbg_idx;
    trit_t [TRIT_WIDTH-1:0]             dbg_data;

    modport master (
        output rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set_en, sb_set_addr, clr_req, dbg_idx,
        input  rs_data, rs_busy, clr_busy, clr_done, wr_conflict, dbg_data
    );

    modport slave (
        input  rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set_en, sb_set_addr, clr_req, dbg_idx,
        output rs_data, rs_busy, clr_busy, clr_done, wr_conflict, dbg_data
    );

endinterface

// File: rtl/ternary_regfile_mp_scoreboard.sv
// Per-register busy scoreboard for outstanding loads.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : clear every busy bit (start of a hardware clear)
//   set_en_i/idx     : mark a register busy (load issued)
//   clr_en_i/idx     : load writeback, mark the register free
//   rd_idx_i         : lookup indices, one per read port
//   rd_busy_o        : busy bit of each looked-up register (stored state only)
module ternary_rf_scoreboard #(
    parameter int unsigned NUM_REGS = 27,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         set_en_i,
    input  logic [IDX_W-1:0]             set_idx_i,
    input  logic                         clr_en_i,
    input  logic [IDX_W-1:0]             clr_idx_i,
    input  logic [NUM_RD-1:0][IDX_W-1:0] rd_idx_i,
    output logic [NUM_RD-1:0]            rd_busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        // A set after the clear: a new load issued in the same cycle wins.
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy_o[i] = busy_q[rd_idx_i[i]];
        end
    end

endmodule

// File: rtl/ternary_regfile_mp.sv
// Multi-port ternary register file: 3**ADDR_TRITS registers of TRIT_WIDTH
// trits, NUM_RD combinational read ports, an ALU write port (wa) and a load
// writeback port (wb), optional write-to-read bypass, a busy scoreboard and a
// sweeping hardware clear sequencer.
//   clk, rst : clock, synchronous active-high reset
//   rf       : slave side of ternary_regfile_mp_if (all data/control signals)
// R0 always reads zero, ignores writes and is never busy.
module ternary_regfile_mp
    import ternary_regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_TRITS = 3,
    parameter int unsigned TRIT_WIDTH = 27,
    parameter int unsigned NUM_RD     = 3,
    parameter bit          BYPASS     = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    ternary_regfile_mp_if.slave  rf
);

    localparam int unsigned NUM_REGS = pow3(ADDR_TRITS);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    typedef trit_t [TRIT_WIDTH-1:0] word_t;

    function automatic logic [IDX_W-1:0] idx_of(input trit_t [ADDR_TRITS-1:0] a);
        trit_t [MaxAddrTrits-1:0] w;
        w                 = '0;
        w[ADDR_TRITS-1:0] = a;
        return IDX_W'(trits_to_index(w));
    endfunction

    word_t                      regs_q [NUM_REGS];
    rf_clr_state_e              state_q;
    logic [IDX_W-1:0]           ptr_q;
    logic                       clr_busy_q, clr_done_q, wr_conflict_q;

    logic [IDX_W-1:0]           wa_idx, wb_idx, set_idx;
    logic                       sweep, wa_we, wb_we, flush;
    logic [NUM_RD-1:0][IDX_W-1:0] rd_idx;
    word_t [NUM_RD-1:0]         rs_data;
    word_t                      dbg_data;
    logic [NUM_RD-1:0]          rs_busy;

    assign wa_idx  = idx_of(rf.wa_addr);
    assign wb_idx  = idx_of(rf.wb_addr);
    assign set_idx = idx_of(rf.sb_set_addr);

    // All core-side writes are ignored while the sweep owns the storage.
    assign sweep = (state_q == ClrSweep);
    assign wa_we = rf.wa_en && (wa_idx != '0) && !sweep;
    assign wb_we = rf.wb_en && (wb_idx != '0) && !sweep;
    assign flush = (state_q == ClrIdle) && rf.clr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            state_q       <= ClrIdle;
            ptr_q         <= IDX_W'(1);
            clr_busy_q    <= 1'b0;
            clr_done_q    <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= wa_we && wb_we && (wa_idx == wb_idx);
            if (wa_we) begin
                regs_q[wa_idx] <= rf.wa_data;
            end
            // Later assignment: wb wins a same-address collision.
            if (wb_we) begin
                regs_q[wb_idx] <= rf.wb_data;
            end
            unique case (state_q)
                ClrIdle: begin
                    if (rf.clr_req) begin
                        state_q    <= ClrSweep;
                        ptr_q      <= IDX_W'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                ClrSweep: begin
                    regs_q[ptr_q] <= '0;
                    if (ptr_q == IDX_W'(NUM_REGS - 1)) begin
                        state_q    <= ClrDone;
                        ptr_q      <= IDX_W'(1);
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                ClrDone: begin
                    state_q    <= ClrIdle;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q <= ClrIdle;
                end
            endcase
        end
    end

    always_comb begin
        rd_idx  = '0;
        rs_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx[i] = idx_of(rf.rs_addr[i]);
            if (rd_idx[i] != '0) begin
                rs_data[i] = regs_q[rd_idx[i]];
                if (BYPASS && !sweep) begin
                    if (rf.wb_en && (wb_idx == rd_idx[i])) begin
                        rs_data[i] = rf.wb_data;
                    end else if (rf.wa_en && (wa_idx == rd_idx[i])) begin
                        rs_data[i] = rf.wa_data;
                    end
                end
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if ((rf.dbg_idx != '0) && (int'(rf.dbg_idx) < int'(NUM_REGS))) begin
            dbg_data = regs_q[rf.dbg_idx];
        end
    end

    ternary_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .set_en_i  (rf.sb_set_en && !sweep),
        .set_idx_i (set_idx),
        .clr_en_i  (wb_we),
        .clr_idx_i (wb_idx),
        .rd_idx_i  (rd_idx),
        .rd_busy_o (rs_busy)
    );

    assign rf.rs_data     = rs_data;
    assign rf.rs_busy     = rs_busy;
    assign rf.dbg_data    = dbg_data;
    assign rf.clr_busy    = clr_busy_q;
    assign rf.clr_done    = clr_done_q;
    assign rf.wr_conflict = wr_conflict_q;

endmodule

// File: doc/ternary_regfile_mp.md
Name: ternary_regfile_mp

Overview:
- Next-generation ternary register file. It is parametrised in register count (3^ADDR_TRITS), trit width and read-port count.
- It has two write ports: an ALU port and a load/writeback port.
- It adds optional write-to-read bypass, a per-register busy scoreboard for outstanding loads, and a multi-cycle hardware clear sequencer.
- It sits in the decode/writeback stages of the ternary core and replaces the fixed 9×27, 2-read/1-write file.

Parameters:
- ADDR_TRITS, 3, register address width in trits; NUM_REGS = 3**ADDR_TRITS (derived, not overridable).
- TRIT_WIDTH, 27, trits per register.
- NUM_RD, 3, number of combinational read ports (1..4).
- BYPASS, 1, 1 = a read returns same-cycle write data for a matching address; 0 = a read returns stored data only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rs_addr  in  NUM_RD × ADDR_TRITS trit_t  read addresses
- rs_data  out  NUM_RD × TRIT_WIDTH trit_t  read data
- rs_busy  out  NUM_RD  scoreboard busy bit of each addressed register
- wa_en / wa_addr / wa_data  in  1 / ADDR_TRITS / TRIT_WIDTH  ALU write port
- wb_en / wb_addr / wb_data  in  1 / ADDR_TRITS / TRIT_WIDTH  load writeback port; clears busy
- sb_set_en / sb_set_addr  in  1 / ADDR_TRITS  mark register busy (load issued)
- clr_req  in  1  start hardware clear sequence
- clr_busy  out  1  clear sequence active
- clr_done  out  1  one-cycle pulse when the clear completes
- wr_conflict  out  1  registered pulse: both write ports targeted the same nonzero register
- dbg_idx  in  $clog2(NUM_REGS)  integer register index
- dbg_data  out  TRIT_WIDTH trit_t  debug read

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address decode: each trit is a digit, with 0→0, +→1, −→2 and any illegal encoding→0. Index = Σ digit_k·3^k, trit 0 being the LSB. Index 0 is R0.
- R0:
  - Always reads T_ZERO on all trits.
  - Writes to R0 are dropped.
  - R0 is never marked busy.
- Reads: combinational.
  - With BYPASS=1, precedence is: wb match (wb_en) > wa match (wa_en) > storage.
  - The bypass is suppressed while clr_busy.
  - dbg_data is zero for idx 0 or idx ≥ NUM_REGS. dbg_data never bypasses.
- Writes: take effect on the clock edge; latency is 1 cycle to storage.
  - Same nonzero address on both ports: wb wins, and wr_conflict=1 in the next cycle.
  - Different addresses: both ports write.
- Scoreboard (one busy bit per register, evaluated each edge):
  - A wb write to addr X clears busy[X].
  - sb_set_en sets busy[sb_set_addr].
  - If a set and a clear hit the same register in the same cycle, the set wins (a new load was issued).
  - wa writes do not touch busy.
  - rs_busy[i] = busy[index(rs_addr[i])], combinational, no bypass of the same-cycle set/clear.
- Clear FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_req=1 → SWEEP with ptr=1, and all busy bits are cleared at this edge.
  - SWEEP:
    - Each cycle regs[ptr] ← zero and ptr++.
    - When ptr = NUM_REGS−1 has been written → DONE.
    - NUM_REGS−1 sweep cycles in total.
    - clr_busy=1.
    - wa/wb/sb_set are ignored; the caller stalls on clr_busy.
    - Reads return current storage.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then → IDLE.
    - Writes are accepted normally in DONE.
  - clr_req during SWEEP/DONE is ignored (not queued).
- Reset:
  - All registers become zero, busy bits become 0, FSM goes to IDLE, ptr=1.
  - clr_busy, clr_done and wr_conflict are 0.
  - Reset during SWEEP aborts immediately, with no clr_done pulse.
  - Combinational outputs reflect the zeroed state in the cycle after reset.

Decomposition:
- ternary_pkg additions:
  - trit_t / T_* already exist.
  - New: function trits_to_index (parametrised digit decode), the rf_clr_state_e enum, and the constant helper pow3().
- One sub-module: ternary_rf_scoreboard, which holds the busy vector with its set/clear/flush logic and read lookups.
- Storage, bypass and the clear FSM stay in the top module.

Test Plan:
- All defaults apply unless stated (ADDR_TRITS=3, TRIT_WIDTH=27, NUM_RD=3).
- Decode/write/read: write +13 to addr (0,+,−) = index 5 via wa → the next cycle rs_addr[0]=(0,+,−) reads +13, and dbg_idx=5 reads +13. Write to (0,0,0) → R0 still reads 0.
- Dual-write conflict: wa=(addr 4, +7) and wb=(addr 4, −2) in the same cycle → reg4 = −2 and wr_conflict=1 for exactly one cycle. wa=(4,+7) with wb=(9,−2) → both written, no conflict.
- Bypass: BYPASS=1, wb writing +100 to reg 8 while rs_addr[1] addresses reg 8 → rs_data[1]=+100 in the same cycle. BYPASS=0 → the old value that cycle and +100 the next.
- Scoreboard: sb_set reg 3 → rs_busy=1. A wb write to reg 3 → busy=0 the next cycle. A simultaneous sb_set and wb on reg 3 → busy stays 1. A wa write to reg 3 → busy is unchanged.
- Clear sequence: fill regs 1..26 with nonzero values and set busy on reg 2, then pulse clr_req → busy=0 immediately. clr_busy stays high for 26 cycles and a wa write during that window is dropped. clr_done pulses once, then all regs read 0.
- Reset mid-clear: assert rst at sweep cycle 10 → no clr_done pulse, FSM is IDLE, all regs read 0. A new clr_req afterwards completes normally.
